// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed byte stream, writes little-endian 32-bit words to imem,
// then releases the core reset. PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module program_loader #(
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int unsigned MAX_WORDS   = 256,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [63:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        imem_we,
    output logic        pc_reset,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        LOAD,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK,
`endif
        HOLD,
        RUN,
        ERR
    } state_t;

    state_t      state;
    logic [15:0] word_count;
    logic [15:0] word_index;
    logic [1:0]  lane;
    logic [23:0] asm_word;
    logic [31:0] hold_cnt;
    logic        xfer;
    logic [15:0] hdr_count;

    assign xfer      = rx_valid && rx_ready;
    assign hdr_count = {rx_data, word_count[7:0]};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= '0;
        end else if (xfer && (state == HDR0 || state == HDR1 || state == LOAD)) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HDR0;
            word_count <= '0;
            word_index <= '0;
            lane       <= '0;
            asm_word   <= '0;
            hold_cnt   <= '0;
            rx_ready   <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            imem_we    <= 1'b0;
            pc_reset   <= 1'b1;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                HDR0: begin
                    busy     <= 1'b1;
                    rx_ready <= 1'b1;
                    if (xfer) begin
                        word_count[7:0] <= rx_data;
                        state           <= HDR1;
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        word_count[15:8] <= rx_data;
                        if (hdr_count == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state <= CHK;
`else
                            state    <= HOLD;
                            rx_ready <= 1'b0;
`endif
                        end else if ({16'd0, hdr_count} > MAX_WORDS) begin
                            state    <= ERR;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // Index reaches the count on the final word's write cycle; leave once it completes.
                    if (word_index == word_count) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state    <= CHK;
                        rx_ready <= 1'b1;
`else
                        state <= HOLD;
`endif
                    end else if (xfer) begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: asm_word[7:0]   <= rx_data;
                            2'd1: asm_word[15:8]  <= rx_data;
                            2'd2: asm_word[23:16] <= rx_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {rx_data, asm_word};
                                imem_addr  <= BASE_ADDR + {46'd0, word_index, 2'b00};
                                word_index <= word_index + 16'd1;
                                if (word_index + 16'd1 == word_count) begin
                                    rx_ready <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum) begin
                            state <= HOLD;
                        end else begin
                            state <= ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                HOLD: begin
                    if (hold_cnt == HOLD_CYCLES - 1) begin
                        state    <= RUN;
                        pc_reset <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
